// File: rtl/multiplicador_secuencial_param.sv
//------------------------------------------------------------------------------
// multiplicador_secuencial_param
//
// Sequential shift-add multiplier, WIDTH x WIDTH -> 2*WIDTH product, with a
// runtime signed/unsigned mode. Operands are reduced to magnitudes on accept,
// multiplied as unsigned numbers, and the sign is re-applied in one final
// step. The loop exits as soon as the multiplier register reaches zero, so
// small multipliers finish early. The done flag is held for DONE_HOLD cycles
// or until the processor acknowledges the result.
//
// Parameters
//   WIDTH      operand width in bits (>= 2)
//   DONE_HOLD  maximum cycles done stays high without ack (>= 1)
//
// Ports
//   clk     in   1        system clock, rising edge
//   rst     in   1        asynchronous reset, active high
//   init    in   1        start request, sampled only in IDLE
//   sgn     in   1        1 = two's-complement operands/result, 0 = unsigned
//   ack     in   1        result consumed, ends DONE early
//   op_a    in   WIDTH    multiplicand, sampled with init
//   op_b    in   WIDTH    multiplier, sampled with init
//   result  out  2*WIDTH  product, valid while done, held until next init
//   busy    out  1        high whenever the FSM is not in IDLE
//   done    out  1        high only in DONE
//------------------------------------------------------------------------------
module multiplicador_secuencial_param #(
   parameter int WIDTH     = 8,
   parameter int DONE_HOLD = 32
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               init,
   input  logic               sgn,
   input  logic               ack,
   input  logic [WIDTH-1:0]   op_a,
   input  logic [WIDTH-1:0]   op_b,
   output logic [2*WIDTH-1:0] result,
   output logic               busy,
   output logic               done
);

   // Counter only needs to reach DONE_HOLD-1; keep at least one bit so the
   // DONE_HOLD=1 case still elaborates.
   localparam int HOLD_W = (DONE_HOLD > 1) ? $clog2(DONE_HOLD) : 1;
   localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(DONE_HOLD - 1);

   typedef enum logic [2:0] {
      S_IDLE,
      S_CHECK,
      S_ADD,
      S_SHIFT,
      S_FIX,
      S_DONE
   } state_t;

   state_t              state, state_nxt;
   logic [2*WIDTH-1:0]  areg;
   logic [WIDTH-1:0]    breg;
   logic [2*WIDTH-1:0]  acc;
   logic                neg;
   logic [HOLD_W-1:0]   hold_cnt;

   // Operand magnitudes. Negating the most negative value wraps back to
   // 2^(WIDTH-1), which is exactly the right magnitude when read unsigned.
   logic [WIDTH-1:0]    mag_a, mag_b;
   logic                neg_in;

   always_comb begin
      mag_a  = (sgn && op_a[WIDTH-1]) ? (~op_a + 1'b1) : op_a;
      mag_b  = (sgn && op_b[WIDTH-1]) ? (~op_b + 1'b1) : op_b;
      neg_in = sgn & (op_a[WIDTH-1] ^ op_b[WIDTH-1]);
   end

   //---------------------------------------------------------------------------
   // State register
   //---------------------------------------------------------------------------
   // NOTE: sequential state uses non-blocking assignments so every register
   // samples the pre-edge values regardless of statement order.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state <= S_IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   //---------------------------------------------------------------------------
   // Next-state and output decode
   //---------------------------------------------------------------------------
   always_comb begin
      // NOTE: defaults first so no path leaves a variable unassigned, which
      // would otherwise infer a latch.
      state_nxt = state;
      busy      = 1'b1;
      done      = 1'b0;

      unique case (state)
         S_IDLE: begin
            busy = 1'b0;
            if (init) state_nxt = S_CHECK;
         end
         S_CHECK: begin
            if (breg == '0)      state_nxt = S_FIX;
            else if (breg[0])    state_nxt = S_ADD;
            else                 state_nxt = S_SHIFT;
         end
         S_ADD:   state_nxt = S_SHIFT;
         S_SHIFT: state_nxt = S_CHECK;
         S_FIX:   state_nxt = S_DONE;
         S_DONE: begin
            done = 1'b1;
            // Ack and hold expiry lead to the same place, so no priority
            // between them is needed.
            if (ack || hold_cnt == HOLD_LAST) state_nxt = S_IDLE;
         end
         default: state_nxt = S_IDLE;
      endcase
   end

   //---------------------------------------------------------------------------
   // Datapath
   //---------------------------------------------------------------------------
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         areg     <= '0;
         breg     <= '0;
         acc      <= '0;
         neg      <= 1'b0;
         hold_cnt <= '0;
         result   <= '0;
      end else begin
         unique case (state)
            S_IDLE: begin
               if (init) begin
                  areg <= {{WIDTH{1'b0}}, mag_a};
                  breg <= mag_b;
                  neg  <= neg_in;
                  acc  <= '0;
               end
            end
            S_ADD: begin
               // Magnitudes fit in 2*WIDTH bits, so the sum cannot overflow.
               acc <= acc + areg;
            end
            S_SHIFT: begin
               areg <= areg << 1;
               breg <= breg >> 1;
            end
            S_FIX: begin
               // Negating a zero accumulator yields zero: no negative zero.
               result   <= neg ? (~acc + 1'b1) : acc;
               hold_cnt <= '0;
            end
            S_DONE: begin
               hold_cnt <= hold_cnt + 1'b1;
            end
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_multiplicador_secuencial_param.sv
//------------------------------------------------------------------------------
// tb_multiplicador_secuencial_param
//
// Directed vectors for the sequential multiplier (WIDTH=8, DONE_HOLD=4).
// Stimulus pushes the hand-computed product, latency and done length into a
// scoreboard queue; a monitor on the falling edge pops an entry on each done
// rising edge and compares.
//------------------------------------------------------------------------------
module tb_multiplicador_secuencial_param;

   localparam int W = 8;
   localparam int H = 4;

   logic           clk = 1'b0;
   logic           rst;
   logic           init;
   logic           sgn;
   logic           ack;
   logic [W-1:0]   op_a;
   logic [W-1:0]   op_b;
   logic [2*W-1:0] result;
   logic           busy;
   logic           done;

   multiplicador_secuencial_param #(
      .WIDTH     (W),
      .DONE_HOLD (H)
   ) dut (
      .clk    (clk),
      .rst    (rst),
      .init   (init),
      .sgn    (sgn),
      .ack    (ack),
      .op_a   (op_a),
      .op_b   (op_b),
      .result (result),
      .busy   (busy),
      .done   (done)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [2*W-1:0] res;
      int             lat;
      int             hold;
   } exp_t;

   exp_t sb_q[$];
   int   n_cmp = 0;
   int   n_err = 0;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
      n_cmp++;
      if (act !== req) begin
         n_err++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, req, $time);
      end
   endtask

   //---------------------------------------------------------------------------
   // Monitor: latency counted from the cycle after the accepting edge (1),
   // result/latency compared on done rise, done length compared on done fall.
   //---------------------------------------------------------------------------
   bit   prev_busy, prev_done, have_cur;
   int   lat_cnt, done_len;
   exp_t cur;

   always @(negedge clk) begin
      if (rst) begin
         prev_busy = 1'b0;
         prev_done = 1'b0;
         have_cur  = 1'b0;
         lat_cnt   = 0;
         done_len  = 0;
      end else begin
         if (busy && !prev_busy) lat_cnt = 1;
         else if (busy)          lat_cnt++;

         if (done && !prev_done) begin
            done_len = 0;
            if (sb_q.size() == 0) begin
               n_cmp++;
               n_err++;
               $display("FAIL unexpected_done: result 0x%0h with empty scoreboard", result);
            end else begin
               cur      = sb_q.pop_front();
               have_cur = 1'b1;
               check("result", result, cur.res);
               check("latency", lat_cnt, cur.lat);
            end
         end
         if (done) done_len++;
         if (!done && prev_done && have_cur) begin
            check("done_len", done_len, cur.hold);
            have_cur = 1'b0;
         end

         prev_busy = busy;
         prev_done = done;
      end
   end

   //---------------------------------------------------------------------------
   // Stimulus helpers
   //---------------------------------------------------------------------------
   task automatic wait_idle();
      int t = 0;
      while (busy && t < 200) begin
         @(negedge clk);
         t++;
      end
      check("idle_timeout", busy, 1'b0);
   endtask

   task automatic wait_done();
      int t = 0;
      while (!done && t < 200) begin
         @(negedge clk);
         t++;
      end
      check("done_timeout", done, 1'b1);
   endtask

   task automatic run_op(input logic [W-1:0] a, input logic [W-1:0] b, input logic s,
                         input logic [2*W-1:0] res, input int lat, input int hold,
                         input bit use_ack);
      exp_t e;
      wait_idle();
      @(negedge clk);
      op_a = a; op_b = b; sgn = s; init = 1'b1;
      e.res = res; e.lat = lat; e.hold = hold;
      sb_q.push_back(e);
      @(negedge clk);
      // Scramble the operands to show they are not re-sampled.
      init = 1'b0; op_a = ~a; op_b = b ^ 8'h5A; sgn = ~s;
      check("busy_after_init", busy, 1'b1);
      wait_done();
      if (use_ack) begin
         ack = 1'b1;
         @(negedge clk);
         ack = 1'b0;
         check("busy_after_ack", busy, 1'b0);
      end
      wait_idle();
      repeat (2) @(negedge clk);
      check("result_held", result, res);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   //---------------------------------------------------------------------------
   // Directed sequence
   //---------------------------------------------------------------------------
   initial begin
      rst = 1'b1; init = 1'b0; sgn = 1'b0; ack = 1'b0; op_a = '0; op_b = '0;
      #12;
      check("rst_result", result, 16'h0000);
      check("rst_busy", busy, 1'b0);
      check("rst_done", done, 1'b0);
      @(negedge clk);
      #2 rst = 1'b0;

      // Unsigned
      run_op(8'd13,  8'd11,  1'b0, 16'd143,   14, H, 1'b0);
      run_op(8'd200, 8'd0,   1'b0, 16'd0,      3, H, 1'b0);
      run_op(8'd255, 8'd255, 1'b0, 16'd65025, 27, H, 1'b0);

      // Signed
      run_op(8'hFD, 8'd5,   1'b1, 16'hFFF1, 11, H, 1'b0);   // -3 * 5
      run_op(8'h80, 8'h80,  1'b1, 16'h4000, 20, H, 1'b0);   // -128 * -128
      run_op(8'd127, 8'h80, 1'b1, 16'hC080, 20, H, 1'b0);   // 127 * -128
      run_op(8'd0,  8'hFF,  1'b1, 16'h0000,  6, H, 1'b0);   // 0 * -1

      // Ack in the first DONE cycle
      run_op(8'd2, 8'd3, 1'b0, 16'd6, 9, 1, 1'b1);

      // init while busy is ignored
      begin
         exp_t e;
         wait_idle();
         @(negedge clk);
         op_a = 8'd13; op_b = 8'd11; sgn = 1'b0; init = 1'b1;
         e.res = 16'd143; e.lat = 14; e.hold = H;
         sb_q.push_back(e);
         @(negedge clk);
         init = 1'b0;
         repeat (3) @(negedge clk);
         op_a = 8'd2; op_b = 8'd2; init = 1'b1;
         @(negedge clk);
         init = 1'b0;
         wait_done();
         wait_idle();
         check("ignored_init_result", result, 16'd143);
      end
      run_op(8'd9, 8'd9, 1'b0, 16'd81, 13, H, 1'b0);

      // Reset while in ADD aborts the operation
      wait_idle();
      @(negedge clk);
      op_a = 8'd5; op_b = 8'd1; sgn = 1'b0; init = 1'b1;
      @(negedge clk);                 // CHECK
      init = 1'b0;
      @(negedge clk);                 // ADD
      #2 rst = 1'b1;
      #1;
      check("abort_done", done, 1'b0);
      check("abort_busy", busy, 1'b0);
      check("abort_result", result, 16'h0000);
      @(negedge clk);
      #2 rst = 1'b0;
      run_op(8'd7, 8'd6, 1'b0, 16'd42, 11, H, 1'b0);

      repeat (4) @(negedge clk);
      check("scoreboard_drained", sb_q.size(), 0);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
